// File: rtl/uart_tx_arbiter.sv
// Two-requester, round-robin arbiter that serialises multi-byte words into a
// transmit FIFO, least-significant byte first, with an idle gap between bytes.
module uart_tx_arbiter #(
    parameter int DBIT   = 8,
    parameter int NBYTES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic [NBYTES*DBIT-1:0]   data0,
    output logic                     ack0,
    input  logic                     req1,
    input  logic [NBYTES*DBIT-1:0]   data1,
    output logic                     ack1,
    input  logic                     fifo_full,
    output logic                     fifo_wr,
    output logic [DBIT-1:0]          fifo_wdata,
    output logic                     busy,
    output logic                     grant
);

    localparam int WW = NBYTES * DBIT;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic [WW-1:0]   shift_r;
    logic [CW-1:0]   cnt_r;
    logic            grant_r;
    logic            last_r;
    logic            busy_r;
    logic            ack0_r;
    logic            ack1_r;
    logic            arb_s;
    logic            any_req_s;
    logic            last_byte_s;
    logic            fifo_wr_s;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        any_req_s = req0 | req1;
        if (req0 && req1) begin
            arb_s = ~last_r;
        end else if (req1) begin
            arb_s = 1'b1;
        end else begin
            arb_s = 1'b0;
        end
    end

    assign last_byte_s = (cnt_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a full FIFO parks the machine in WRITE indefinitely.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_s = LOAD;
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: next_s = WRITE;
            WRITE: begin
                if (fifo_full) begin
                    next_s = WRITE;
                end else if (last_byte_s) begin
                    next_s = DONE;
                end else begin
                    next_s = GAP;
                end
            end
            GAP:  next_s = WRITE;
            DONE: next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Write strobe follows fifo_full combinationally so a freed slot is used at once.
    always_comb begin
        fifo_wr_s = 1'b0;
        case (state_r)
            WRITE:   fifo_wr_s = ~fifo_full;
            default: fifo_wr_s = 1'b0;
        endcase
    end

    // Grant, shift register, byte counter and last-served pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            shift_r <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        grant_r <= arb_s;
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                LOAD: begin
                    shift_r <= grant_r ? data1 : data0;
                    cnt_r   <= '0;
                end
                WRITE: begin
                    if (!fifo_full) begin
                        shift_r <= shift_r >> DBIT;
                        cnt_r   <= cnt_r + CW'(1);
                    end else begin
                        shift_r <= shift_r;
                        cnt_r   <= cnt_r;
                    end
                end
                DONE: last_r <= grant_r;
                default: begin
                    shift_r <= shift_r;
                    cnt_r   <= cnt_r;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
        end else begin
            busy_r <= (next_s != IDLE);
            ack0_r <= (next_s == DONE) && !grant_r;
            ack1_r <= (next_s == DONE) &&  grant_r;
        end
    end

    assign fifo_wr    = fifo_wr_s;
    assign fifo_wdata = shift_r[DBIT-1:0];
    assign busy       = busy_r;
    assign grant      = grant_r;
    assign ack0       = ack0_r;
    assign ack1       = ack1_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table on a 2-byte
// instance plus a hand-written sequence on a 3-byte instance.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req0, req1, fifo_full;
    logic [15:0] data0, data1;
    logic        ack0, ack1, fifo_wr, busy, grant;
    logic [7:0]  fifo_wdata;

    logic        reset_b, req0_b, req1_b, full_b;
    logic [23:0] data0_b, data1_b;
    logic        ack0_b, ack1_b, wr_b, busy_b, grant_b;
    logic [7:0]  wdata_b;

    uart_tx_arbiter #(.DBIT(8), .NBYTES(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .busy(busy), .grant(grant)
    );

    uart_tx_arbiter #(.DBIT(8), .NBYTES(3)) dut3 (
        .clk(clk), .reset(reset_b),
        .req0(req0_b), .data0(data0_b), .ack0(ack0_b),
        .req1(req1_b), .data1(data1_b), .ack1(ack1_b),
        .fifo_full(full_b), .fifo_wr(wr_b), .fifo_wdata(wdata_b),
        .busy(busy_b), .grant(grant_b)
    );

    // ctl = {reset, req0, req1, fifo_full}; ex = {wr, check_wdata, ack0, ack1, busy, check_grant, grant}
    typedef struct {
        logic [3:0]  ctl;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [6:0]  ex;
        logic [7:0]  wd;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic [3:0] ctl, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [6:0] ex, input logic [7:0] wd);
        vec_t v;
        v.ctl = ctl; v.d0 = d0; v.d1 = d1; v.ex = ex; v.wd = wd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
        data0 = 16'h0000; data1 = 16'h0000;
        reset_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; full_b = 1'b0;
        data0_b = 24'h000000; data1_b = 24'h000000;

        // Single request A55A, ack0 at cycle 5
        add(4'b0100, 16'hA55A, 16'h0000, 7'b0000010, 8'h00);
        add(4'b0100, 16'hA55A, 16'h0000, 7'b0000110, 8'h00);
        add(4'b0100, 16'hA55A, 16'h0000, 7'b1100110, 8'h5A);
        add(4'b0100, 16'hA55A, 16'h0000, 7'b0000110, 8'h00);
        add(4'b0100, 16'hA55A, 16'h0000, 7'b1100110, 8'hA5);
        add(4'b0000, 16'hA55A, 16'h0000, 7'b0010110, 8'h00);
        add(4'b1000, 16'hA55A, 16'h0000, 7'b0000000, 8'h00);
        // Tie after reset, grants alternate 0,1,0,1
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000010, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100110, 8'h34);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100110, 8'h12);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0010110, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000000, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000111, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100111, 8'hEF);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000111, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100111, 8'hBE);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0001111, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000000, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100110, 8'h34);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100110, 8'h12);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0010110, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000000, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000111, 8'h00);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100111, 8'hEF);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b0000111, 8'h00);
        // Backpressure on byte1 for 3 cycles, ack1 three cycles late
        add(4'b0111, 16'h1234, 16'hBEEF, 7'b0100111, 8'hBE);
        add(4'b0111, 16'h1234, 16'hBEEF, 7'b0100111, 8'hBE);
        add(4'b0111, 16'h1234, 16'hBEEF, 7'b0100111, 8'hBE);
        add(4'b0110, 16'h1234, 16'hBEEF, 7'b1100111, 8'hBE);
        add(4'b0000, 16'h1234, 16'hBEEF, 7'b0001111, 8'h00);
        // Reset the cycle after byte0, then CAFE from byte0
        add(4'b0100, 16'h1234, 16'hBEEF, 7'b0000000, 8'h00);
        add(4'b0100, 16'h1234, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0100, 16'h1234, 16'hBEEF, 7'b1100110, 8'h34);
        add(4'b1100, 16'h1234, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0100, 16'hCAFE, 16'hBEEF, 7'b0000010, 8'h00);
        add(4'b0100, 16'hCAFE, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0100, 16'hCAFE, 16'hBEEF, 7'b1100110, 8'hFE);
        add(4'b0100, 16'hCAFE, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0100, 16'hCAFE, 16'hBEEF, 7'b1100110, 8'hCA);
        add(4'b0000, 16'hCAFE, 16'hBEEF, 7'b0010110, 8'h00);
        // Dropped request in GAP and data change after LOAD
        add(4'b0100, 16'h7E81, 16'hBEEF, 7'b0000000, 8'h00);
        add(4'b0100, 16'h7E81, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0100, 16'hFFFF, 16'hBEEF, 7'b1100110, 8'h81);
        add(4'b0000, 16'hFFFF, 16'hBEEF, 7'b0000110, 8'h00);
        add(4'b0000, 16'hFFFF, 16'hBEEF, 7'b1100110, 8'h7E);
        add(4'b0000, 16'hFFFF, 16'hBEEF, 7'b0010110, 8'h00);
        add(4'b0000, 16'hFFFF, 16'hBEEF, 7'b0000000, 8'h00);
        add(4'b0000, 16'hFFFF, 16'hBEEF, 7'b0000000, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            {reset, req0, req1, fifo_full} = vecs[i].ctl;
            data0 = vecs[i].d0;
            data1 = vecs[i].d1;
            @(negedge clk);
            chk($sformatf("row%0d fifo_wr", i), {7'b0000000, fifo_wr}, {7'b0000000, vecs[i].ex[6]});
            if (vecs[i].ex[5]) begin
                chk($sformatf("row%0d fifo_wdata", i), fifo_wdata, vecs[i].wd);
            end else begin
                checks = checks;
            end
            chk($sformatf("row%0d ack0", i), {7'b0000000, ack0}, {7'b0000000, vecs[i].ex[4]});
            chk($sformatf("row%0d ack1", i), {7'b0000000, ack1}, {7'b0000000, vecs[i].ex[3]});
            chk($sformatf("row%0d busy", i), {7'b0000000, busy}, {7'b0000000, vecs[i].ex[2]});
            if (vecs[i].ex[1]) begin
                chk($sformatf("row%0d grant", i), {7'b0000000, grant}, {7'b0000000, vecs[i].ex[0]});
            end else begin
                checks = checks;
            end
            @(posedge clk);
            #1;
        end

        // Three-byte word 112233: bytes at cycles 2,4,6 and ack0 at cycle 7
        for (int k = 0; k < 10; k++) begin
            reset_b = 1'b0;
            req0_b  = (k < 7);
            data0_b = 24'h112233;
            @(negedge clk);
            chk($sformatf("n3 c%0d fifo_wr", k), {7'b0000000, wr_b},
                {7'b0000000, (k == 2 || k == 4 || k == 6)});
            if (k == 2) chk("n3 byte0", wdata_b, 8'h33);
            else if (k == 4) chk("n3 byte1", wdata_b, 8'h22);
            else if (k == 6) chk("n3 byte2", wdata_b, 8'h11);
            else checks = checks;
            chk($sformatf("n3 c%0d ack0", k), {7'b0000000, ack0_b}, {7'b0000000, (k == 7)});
            chk($sformatf("n3 c%0d ack1", k), {7'b0000000, ack1_b}, 8'h00);
            chk($sformatf("n3 c%0d busy", k), {7'b0000000, busy_b},
                {7'b0000000, (k >= 1 && k <= 7)});
            if (k >= 1 && k <= 7) chk($sformatf("n3 c%0d grant", k), {7'b0000000, grant_b}, 8'h00);
            else checks = checks;
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DBIT, default 8, bits per byte written to the transmit FIFO.
REQ-002 Parameter NBYTES, default 2, bytes per requester word (legal range 1..8).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 wants to send a word; held high until ack0.
REQ-006 data0  input  NBYTES*DBIT  requester 0 word; captured once on grant.
REQ-007 ack0  output  1  one-cycle pulse when requester 0's last byte has been written.
REQ-008 req1, data1, ack1  same as REQ-005..REQ-007, for requester 1.
REQ-009 fifo_full  input  1  transmit FIFO cannot accept a write this cycle.
REQ-010 fifo_wr  output  1  one-cycle write strobe to the transmit FIFO.
REQ-011 fifo_wdata  output  DBIT  byte presented with fifo_wr.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant  output  1  index of the requester currently owning the FIFO; valid while busy.

Function
REQ-014 The state machine SHALL have five states: IDLE, LOAD, WRITE, GAP, DONE.
REQ-015 IDLE, no req: the FSM SHALL stay in IDLE.
REQ-016 IDLE, any req: the FSM SHALL register grant and go to LOAD.
REQ-017 Arbitration SHALL be round-robin. With only one req high, that requester wins. With both high, the requester not served last wins.
REQ-018 LOAD: the FSM SHALL copy the granted data into a shift register, clear the byte counter, and go to WRITE.
REQ-019 WRITE: fifo_wr SHALL equal !fifo_full (combinational), and fifo_wdata SHALL equal the shift register bits [DBIT-1:0], least-significant byte first.
REQ-020 WRITE with fifo_full=1: the FSM SHALL stay in WRITE, keep fifo_wdata stable, and write nothing. It SHALL wait indefinitely.
REQ-021 WRITE with fifo_full=0: the shift register SHALL shift right by DBIT and the counter SHALL increment.
REQ-022 After that write, the next state SHALL be DONE if it was byte NBYTES-1, otherwise GAP.
REQ-023 GAP: fifo_wr SHALL be 0 for exactly one cycle, then the FSM SHALL return to WRITE.
REQ-024 DONE: ack of the granted requester SHALL be 1 for exactly one cycle, the last-served pointer SHALL be updated to grant, and the next state SHALL be IDLE.
REQ-025 Latency: with no fifo_full stall, ack SHALL occur 2*NBYTES+1 cycles after the IDLE cycle in which req was sampled.
REQ-026 A req deasserted after grant SHALL be ignored; the word SHALL complete and ack SHALL still pulse.
REQ-027 req still high in IDLE after its ack SHALL be treated as a new request and arbitrated normally.
REQ-028 data0/data1 changes after LOAD SHALL NOT affect bytes already captured.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle, and fifo_wr SHALL never be high outside WRITE.

Reset
REQ-030 reset=1 SHALL force, on the next edge: state IDLE; fifo_wr, ack0, ack1, busy and grant 0; shift register and counter 0; last-served pointer 1 (so req0 wins the first tie).
REQ-031 reset SHALL override every other input, including in mid-transfer. An interrupted word SHALL be abandoned with no ack.

Verification
REQ-032 Single request: reset, then req0=1 with data0=16'hA55A, fifo_full=0, req sampled at cycle 0 -> fifo_wr at cycle 2 with 8'h5A, fifo_wr at cycle 4 with 8'hA5, ack0 at cycle 5, ack1 never asserted.
REQ-033 Tie after reset: req0 and req1 both high, data0=16'h1234, data1=16'hBEEF -> bytes written in order 34,12 (ack0), then EF,BE (ack1). With both requests held high, grants SHALL alternate 0,1,0,1.
REQ-034 Backpressure: fifo_full=1 for 3 cycles in WRITE before byte1 -> no fifo_wr during those 3 cycles, fifo_wdata held at the byte1 value, write on the first cycle with fifo_full=0, ack delayed by exactly 3 cycles.
REQ-035 Reset mid-transfer: reset pulsed the cycle after byte0 is written -> busy=0 and no ack. A following req0 with 16'hCAFE writes FE,CA from byte0.
REQ-036 Dropped request: req0 deasserted in the first GAP -> both bytes still written and ack0 pulses.
REQ-037 NBYTES=3, data0=24'h112233 -> bytes 33,22,11 written; ack0 at cycle 7.
